uart_prog_loader: RTL and testbench

Parametrised program loader that sits between the `uart_rx` byte receiver and the instruction memory write port, and owns the CPU core's reset and run-enable. It accepts framed program images of configurable word width and depth, assembles little-endian bytes into words, and verifies a checksum. It reports overflow, checksum and inter-byte-timeout errors, and supports reloading a new image while the CPU is running.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/word_assembler.sv | 50 +++++
 rtl/uart_prog_loader.sv | 167 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types, error codes and helpers for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Bytes per instruction word.
  function automatic int word_bytes(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word assembly with running XOR
module word_assembler
  import loader_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              clear,
  output logic [WORD_W-1:0] word_data,
  output logic              word_done,
  output logic [7:0]        xor_sum
);

  localparam int WB    = word_bytes(WORD_W);
  localparam int IDX_W = (WB > 1) ? $clog2(WB) : 1;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] acc;
  logic [7:0]        xor_base;

  // A clear coinciding with a byte means that byte opens a fresh frame.
  always_comb begin
    cur_idx   = clear ? '0 : idx;
    xor_base  = clear ? 8'h00 : xor_sum;
    word_done = byte_valid && (cur_idx == IDX_W'(WB - 1));
    word_data = (clear ? '0 : acc) | (WORD_W'(byte_data) << (8 * cur_idx));
  end

  // Byte index, partial word and checksum accumulator.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx     <= '0;
      acc     <= '0;
      xor_sum <= 8'h00;
    end else if (byte_valid) begin
      idx     <= word_done ? '0 : IDX_W'(cur_idx + 1'b1);
      acc     <= word_done ? '0 : word_data;
      xor_sum <= xor_base ^ byte_data;
    end else if (clear) begin
      idx     <= '0;
      acc     <= '0;
      xor_sum <= 8'h00;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed program image loader owning CPU reset and run-enable
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              start_btn,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              cpu_run_en,
  output logic              loading,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CMP_W  = (WORD_W > ADDR_W + 1) ? WORD_W : ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CMP_W-1:0] CAP = CMP_W'(1) << ADDR_W;

  state_t state, state_n;

  logic              start_q, start_rise;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [ADDR_W:0]   n_target, n_n, wl_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [WORD_W-1:0] wdata_n;
  logic [1:0]        err_n;
  logic              we_n, loading_n, run_en_n, restart, count_done;
  logic              asm_valid, asm_clear, asm_done;
  logic [WORD_W-1:0] asm_word;
  logic [7:0]        asm_xor;
  logic [CMP_W-1:0]  n_ext;

  assign start_rise = start_btn && !start_q;
  assign asm_clear  = rx_valid && (state inside {ST_IDLE, ST_DONE, ST_RUN});
  assign asm_valid  = rx_valid && (state inside {ST_IDLE, ST_COUNT, ST_LOAD, ST_DONE, ST_RUN});
  assign n_ext      = CMP_W'(asm_word);

  word_assembler #(.WORD_W(WORD_W)) u_asm (
    .CLK        (CLK),
    .RESET      (RESET),
    .byte_data  (rx_data),
    .byte_valid (asm_valid),
    .clear      (asm_clear),
    .word_data  (asm_word),
    .word_done  (asm_done),
    .xor_sum    (asm_xor)
  );

  // Next-state and next-output logic; bytes win over the start edge.
  always_comb begin
    state_n    = state;
    we_n       = 1'b0;
    waddr_n    = imem_waddr;
    wdata_n    = imem_wdata;
    err_n      = err_code;
    wl_n       = words_loaded;
    n_n        = n_target;
    idle_n     = '0;
    restart    = 1'b0;
    count_done = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_RUN: begin
        if (rx_valid) begin
          state_n    = ST_COUNT;
          count_done = asm_done;
        end else if (start_rise && state != ST_IDLE) begin
          state_n = ST_RUN;
          restart = (state == ST_RUN);
        end
      end
      ST_COUNT: count_done = asm_done;
      ST_LOAD: begin
        if (asm_done) begin
          we_n    = 1'b1;
          wdata_n = asm_word;
          waddr_n = words_loaded[ADDR_W-1:0];
          wl_n    = words_loaded + 1'b1;
          if (wl_n == n_target) state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == asm_xor) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_ERROR;
            err_n   = ERR_CHECKSUM;
          end
        end
      end
      ST_ERROR: begin
        if (start_rise) begin
          state_n = ST_IDLE;
          err_n   = ERR_NONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (count_done) begin
      waddr_n = '0;
      wl_n    = '0;
      n_n     = n_ext[ADDR_W:0];
      if (n_ext > CAP) begin
        state_n = ST_ERROR;
        err_n   = ERR_OVERFLOW;
      end else if (n_ext == '0) begin
        state_n = ST_CHECK;
      end else begin
        state_n = ST_LOAD;
      end
    end

    if ((state inside {ST_COUNT, ST_LOAD, ST_CHECK}) && !rx_valid) begin
      if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
        state_n = ST_ERROR;
        err_n   = ERR_TIMEOUT;
      end else begin
        idle_n = idle_cnt + 1'b1;
      end
    end

    loading_n = state_n inside {ST_COUNT, ST_LOAD, ST_CHECK};
    run_en_n  = (state_n == ST_RUN) && !restart;
  end

  // State and registered outputs; cpu_rst is always the complement of run-enable.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      idle_cnt     <= '0;
      n_target     <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      cpu_run_en   <= 1'b0;
      loading      <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      start_q      <= start_btn;
      idle_cnt     <= idle_n;
      n_target     <= n_n;
      imem_we      <= we_n;
      imem_waddr   <= waddr_n;
      imem_wdata   <= wdata_n;
      cpu_rst      <= !run_en_n;
      cpu_run_en   <= run_en_n;
      loading      <= loading_n;
      err_code     <= err_n;
      words_loaded <= wl_n;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 4;
  localparam int TCYC   = 20;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              start_btn;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              cpu_run_en;
  logic              loading;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  logic [7:0] fb[$];

  uart_prog_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .start_btn    (start_btn),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .cpu_run_en   (cpu_run_en),
    .loading      (loading),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic start_pulse();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (!RESET && imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {28'h0, imem_waddr}, 32'hffff_ffff);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", imem_waddr, w.addr);
        chk("wr_data", imem_wdata, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; start_btn = 1'b0;
    tick(3);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_run_en", cpu_run_en, 0);
    chk("rst_loading", loading, 0);
    chk("rst_err", err_code, 0);
    chk("rst_words", words_loaded, 0);
    RESET = 1'b0;
    tick(1);

    // good frame
    fb = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    send_byte(fb[0]);
    chk("good_loading_mid", loading, 1);
    send_list(fb[1:$]);
    send_byte(xsum(fb));
    chk("good_loading_done", loading, 0);
    chk("good_err", err_code, 0);
    chk("good_words", words_loaded, 2);
    chk("good_cpu_rst", cpu_rst, 1);
    chk("good_run_en", cpu_run_en, 0);

    // start and restart
    start_pulse();
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_run_en", cpu_run_en, 1);
    tick(1);
    start_pulse();
    chk("restart_cpu_rst", cpu_rst, 1);
    chk("restart_run_en", cpu_run_en, 0);
    tick(1);
    chk("restart_after_rst", cpu_rst, 0);
    chk("restart_after_run", cpu_run_en, 1);

    // reload from RUN with a coinciding start edge
    fb = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    push_wr(0, 16'hBBAA);
    start_btn = 1'b1;
    send_byte(fb[0]);
    start_btn = 1'b0;
    chk("reload_run_en", cpu_run_en, 0);
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_loading", loading, 1);
    send_list(fb[1:$]);
    send_byte(xsum(fb));
    chk("reload_cks_model", xsum(fb), 8'h10);
    chk("reload_words", words_loaded, 1);
    chk("reload_loading_done", loading, 0);
    chk("reload_err", err_code, 0);
    chk("reload_done_rst", cpu_rst, 1);

    // bad checksum
    fb = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    send_list(fb);
    send_byte(8'h00);
    chk("badcks_err", err_code, 2);
    chk("badcks_loading", loading, 0);
    send_byte(8'h02);
    chk("err_ignores_bytes", loading, 0);
    start_pulse();
    chk("badcks_clear", err_code, 0);

    // overflow: N = 17 > 16
    send_byte(8'h11);
    chk("ovf_first", err_code, 0);
    send_byte(8'h00);
    chk("ovf_err", err_code, 1);
    chk("ovf_loading", loading, 0);
    tick(2);
    start_pulse();
    chk("ovf_clear", err_code, 0);

    // timeout fires after TCYC idle cycles
    send_list('{8'h02, 8'h00, 8'h34});
    tick(TCYC - 1);
    chk("tmo_not_yet", err_code, 0);
    chk("tmo_still_loading", loading, 1);
    tick(1);
    chk("tmo_err", err_code, 3);
    chk("tmo_loading", loading, 0);
    start_pulse();
    chk("tmo_clear", err_code, 0);

    // TCYC-1 idle cycles are tolerated
    fb = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    send_list(fb[0:2]);
    tick(TCYC - 1);
    send_list(fb[3:$]);
    send_byte(xsum(fb));
    chk("edge_err", err_code, 0);
    chk("edge_words", words_loaded, 2);

    // reset mid-frame
    send_list('{8'h01, 8'h00});
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("midrst_loading", loading, 0);
    chk("midrst_words", words_loaded, 0);
    chk("midrst_cpu_rst", cpu_rst, 1);

    tick(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
